tff_bank: RTL

- Parametrised successor to the single-bit toggle flip-flop: a WIDTH-bit bank of async-reset T flip-flops.
- One shared toggle-mask generator lets the bank run as:
  - independent toggle cells,
  - a synchronous up counter,
  - a synchronous down counter,
  - a loadable register.
- Provides a registered terminal-count pulse.
- Used as the general counter/divider/toggle primitive in the sequential library.

---
 rtl/tff_bank_pkg.sv | 14 +
 rtl/tff_bank_cell.sv | 23 ++
 rtl/tff_bank.sv | 106 ++++++++++
 3 files changed

// File: rtl/tff_bank_pkg.sv
// Shared definitions for the tff_bank toggle/counter primitive.
// Holds mode encodings and the wrap-counter width.
package tff_bank_pkg;

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'd0,
    MODE_UP     = 2'd1,
    MODE_DOWN   = 2'd2,
    MODE_LOAD   = 2'd3
  } mode_e;

  localparam int unsigned WRAPCNT_W = 16;

endpackage : tff_bank_pkg

// File: rtl/tff_bank_cell.sv
// Single T flip-flop: async active-high reset to INIT, sync clear, toggle input.
module tff_cell #(
  parameter bit INIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic t_i,
  output logic q_o
);

  logic q_q;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      q_q <= INIT;
    else if (clr_i) q_q <= INIT;
    else if (t_i)   q_q <= ~q_q;
  end

  assign q_o = q_q;

endmodule : tff_cell

// File: rtl/tff_bank.sv
// WIDTH-bit bank of T flip-flops driven by one toggle-mask generator
// (toggle / up / down / load) with a registered terminal-count pulse.
// Optional wrap counter output enabled by macro TFF_BANK_WRAPCNT_EN.
module tff_bank
  import tff_bank_pkg::*;
#(
  parameter int unsigned          WIDTH    = 4,
  parameter logic [WIDTH-1:0]     INIT_VAL = '0,
  parameter bit                   SATURATE = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clr,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     t_vec,
  input  logic [WIDTH-1:0]     load_val,
  output logic [WIDTH-1:0]     q,
  output logic                 tc
`ifdef TFF_BANK_WRAPCNT_EN
  ,
  output logic [WRAPCNT_W-1:0] wrap_cnt
`endif
);

  mode_e            mode_s;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] toggle;
  logic             limit_evt;
  logic             run;
  logic             tc_q, tc_d;

  assign mode_s = mode_e'(mode);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    mask = '0;
    run  = 1'b1;
    case (mode_s)
      MODE_TOGGLE: mask = t_vec;
      MODE_UP: begin
        for (int i = 0; i < int'(WIDTH); i++) begin
          mask[i] = run;
          run     = run & q[i];
        end
      end
      MODE_DOWN: begin
        for (int i = 0; i < int'(WIDTH); i++) begin
          mask[i] = run;
          run     = run & ~q[i];
        end
      end
      MODE_LOAD: mask = q ^ load_val;
    endcase
  end

  assign limit_evt = en && !clr &&
                     (((mode_s == MODE_UP)   && (&q)) ||
                      ((mode_s == MODE_DOWN) && (~|q)));

  // Saturating counters freeze at the limit instead of wrapping.
  always_comb begin
    toggle = '0;
    if (en && !(SATURATE && limit_evt)) toggle = mask;
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    tff_cell #(.INIT(INIT_VAL[i])) u_cell (
      .clk   (clk),
      .reset (reset),
      .clr_i (clr),
      .t_i   (toggle[i]),
      .q_o   (q[i])
    );
  end

  // limit_evt already excludes clr, so a clear edge always schedules tc = 0.
  assign tc_d = limit_evt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tc_q <= 1'b0;
    else       tc_q <= tc_d;
  end

  assign tc = tc_q;

`ifdef TFF_BANK_WRAPCNT_EN
  logic [WRAPCNT_W-1:0] wrap_cnt_q, wrap_cnt_d;

  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (clr)
      wrap_cnt_d = '0;
    else if (!SATURATE && limit_evt && (wrap_cnt_q != '1))
      wrap_cnt_d = wrap_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wrap_cnt_q <= '0;
    else       wrap_cnt_q <= wrap_cnt_d;
  end

  assign wrap_cnt = wrap_cnt_q;
`endif

endmodule : tff_bank
